// File: rtl/seg7_scan_mux.sv
// Multiplexed NUM_DIGITS-digit seven-segment scanner with frame-synchronous double-buffered BCD.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_COUNT = 4000,
  parameter int BLANK_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic [6:0]              led_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int MAXC = (REFRESH_COUNT > BLANK_CYCLES) ? REFRESH_COUNT : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_COUNT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    pending_q, pending_d;
  logic [6:0]              led_q, led_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    done_q, done_d;
  logic                    wrap;
  logic                    blank_cur;
  logic [3:0]              nib [NUM_DIGITS];

  genvar gi;

  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = active_q[4*gi +: 4];
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Digit k is suppressed when it and every more-significant digit are zero.
  logic [NUM_DIGITS-1:0] lz_blank;
  assign lz_blank[0] = 1'b0;
  for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign lz_blank[gi] = (active_q[4*NUM_DIGITS-1:4*gi] == '0);
  end
  assign blank_cur = lz_blank[idx_d];
`else
  assign blank_cur = 1'b0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    wrap    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // A load coinciding with the frame wrap bypasses the shadow so it is not lost for a frame.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wrap) begin
      if (load) begin
        shadow_d  = digits_in;
        active_d  = digits_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end
  end

  // Outputs follow the next state; active_q only changes on edges that enter BLANK.
  always_comb begin
    led_d  = 7'b0000000;
    en_d   = '0;
    done_d = wrap;
    if (state_d == ST_SHOW) begin
      en_d  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
      led_d = blank_cur ? 7'b0000000 : seg7(nib[idx_d]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_BLANK;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      led_q     <= 7'b0000000;
      en_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      led_q     <= led_d;
      en_q      <= en_d;
      done_q    <= done_d;
    end
  end

  assign led_out    = led_q;
  assign digit_en   = en_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized self-checking bench for seg7_scan_mux (4 digits, 4-cycle slots, 2-cycle blanking).
module tb_seg7_scan_mux;

  localparam int FRAME = 24;
  localparam int SLOT  = 6;
  localparam int BLNK  = 2;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [6:0]  led_out;
  logic [3:0]  digit_en;
  logic        frame_done;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          e = 0;
  logic [15:0] m_active = 16'h0;
  logic [15:0] m_shadow = 16'h0;
  logic        m_pending = 1'b0;

  seg7_scan_mux #(.NUM_DIGITS(4), .REFRESH_COUNT(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .load(load),
    .led_out(led_out), .digit_en(digit_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected outputs after e edges since reset release, from frame arithmetic.
  function automatic logic [3:0] exp_en();
    int p = e % FRAME;
    logic [3:0] oh = 4'b0001;
    if ((p % SLOT) < BLNK) return 4'b0000;
    return oh << (p / SLOT);
  endfunction

  function automatic logic [6:0] exp_led();
    int p = e % FRAME;
    int d = p / SLOT;
    logic [15:0] sh;
    if ((p % SLOT) < BLNK) return 7'b0000000;
    sh = m_active >> (4 * d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d >= 1 && sh == 16'h0) return 7'b0000000;
`endif
    return SEG_TBL[sh[3:0]];
  endfunction

  function automatic logic exp_fd();
    return (e > 0) && (e % FRAME == 0);
  endfunction

  task automatic model_reset();
    e = 0; m_active = 16'h0; m_shadow = 16'h0; m_pending = 1'b0;
  endtask

  // Drive inputs, clock once, update model, return at the following negedge.
  task automatic tick(input logic ld, input logic [15:0] din);
    load = ld;
    digits_in = din;
    @(posedge clk);
    e++;
    if (e % FRAME == 0) begin
      if (ld) begin m_active = din; m_shadow = din; m_pending = 1'b0; end
      else if (m_pending) begin m_active = m_shadow; m_pending = 1'b0; end
    end else if (ld) begin
      m_shadow = din; m_pending = 1'b1;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (led_out !== 7'b0) begin n_bad++; $display("FAIL reset_led got %b want 0000000", led_out); end
    n_cmp++; if (digit_en !== 4'b0) begin n_bad++; $display("FAIL reset_en got %b want 0000", digit_en); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd got %b want 0", frame_done); end
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 16'h0);
      n_cmp++; if (led_out !== exp_led()) begin n_bad++; $display("FAIL rel_led e=%0d got %b want %b", e, led_out, exp_led()); end
      n_cmp++; if (digit_en !== exp_en()) begin n_bad++; $display("FAIL rel_en e=%0d got %b want %b", e, digit_en, exp_en()); end
      n_cmp++; if (frame_done !== exp_fd()) begin n_bad++; $display("FAIL rel_fd e=%0d got %b want %b", e, frame_done, exp_fd()); end
    end
    $display("test_reset done: e=%0d compared=%0d", e, n_cmp);
  endtask

  task automatic test_scan_order();
    logic [6:0] want [4] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
    logic [3:0] oh = 4'b0001;
    int fd_cnt = 0;
    tick(1'b1, 16'h4321);
    while (e < 2 * FRAME) begin
      tick(1'b0, 16'h0);
      if (e > FRAME && frame_done === 1'b1) fd_cnt++;
      n_cmp++; if (led_out !== exp_led()) begin n_bad++; $display("FAIL scan_led e=%0d got %b want %b", e, led_out, exp_led()); end
      n_cmp++; if (digit_en !== exp_en()) begin n_bad++; $display("FAIL scan_en e=%0d got %b want %b", e, digit_en, exp_en()); end
      n_cmp++; if (frame_done !== exp_fd()) begin n_bad++; $display("FAIL scan_fd e=%0d got %b want %b", e, frame_done, exp_fd()); end
      if (e > FRAME && (e % SLOT) == BLNK) begin
        n_cmp++; if (led_out !== want[(e % FRAME) / SLOT] || digit_en !== (oh << ((e % FRAME) / SLOT)))
          begin n_bad++; $display("FAIL scan_order e=%0d got %b/%b want %b", e, digit_en, led_out, want[(e % FRAME) / SLOT]); end
      end
    end
    n_cmp++; if (fd_cnt != 1) begin n_bad++; $display("FAIL frame_done_count got %0d want 1", fd_cnt); end
    $display("test_scan_order done: e=%0d frame_done pulses=%0d", e, fd_cnt);
  endtask

  task automatic test_double_buffer();
    while (e % FRAME != 13) tick(1'b0, 16'h0);
    tick(1'b1, 16'h9999);
    do begin
      tick(1'b0, 16'h0);
      n_cmp++; if (led_out !== exp_led()) begin n_bad++; $display("FAIL dbuf_led e=%0d got %b want %b", e, led_out, exp_led()); end
      n_cmp++; if (digit_en !== exp_en()) begin n_bad++; $display("FAIL dbuf_en e=%0d got %b want %b", e, digit_en, exp_en()); end
    end while (e % FRAME != 2);
    n_cmp++; if (led_out !== 7'b1111011) begin n_bad++; $display("FAIL dbuf_first got %b want 1111011", led_out); end
    $display("test_double_buffer done: e=%0d led=%b", e, led_out);
  endtask

  task automatic test_wrap_load();
    while (e % FRAME != 23) tick(1'b0, 16'h0);
    tick(1'b1, 16'h0007);
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL wrap_fd got %b want 1", frame_done); end
    tick(1'b0, 16'h0);
    tick(1'b0, 16'h0);
    n_cmp++; if (led_out !== 7'b1110000 || digit_en !== 4'b0001)
      begin n_bad++; $display("FAIL wrap_load got %b/%b want 0001/1110000", digit_en, led_out); end
    for (int i = 0; i < FRAME + 4; i++) begin
      tick(1'b0, 16'h0);
      n_cmp++; if (led_out !== exp_led()) begin n_bad++; $display("FAIL wrap_led e=%0d got %b want %b", e, led_out, exp_led()); end
    end
    $display("test_wrap_load done: e=%0d", e);
  endtask

  task automatic test_invalid_bcd();
    tick(1'b1, 16'hFA00);
    while (e % FRAME != 0) tick(1'b0, 16'h0);
    while (e % FRAME != 20) begin
      tick(1'b0, 16'h0);
      n_cmp++; if (led_out !== exp_led()) begin n_bad++; $display("FAIL inv_led e=%0d got %b want %b", e, led_out, exp_led()); end
      n_cmp++; if (digit_en !== exp_en()) begin n_bad++; $display("FAIL inv_en e=%0d got %b want %b", e, digit_en, exp_en()); end
    end
    n_cmp++; if (led_out !== 7'b0 || digit_en !== 4'b1000)
      begin n_bad++; $display("FAIL inv_digit3 got %b/%b want 1000/0000000", digit_en, led_out); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (led_out !== 7'b0 || digit_en !== 4'b0 || frame_done !== 1'b0)
      begin n_bad++; $display("FAIL async_reset got %b/%b/%b want 0000/0000000/0", digit_en, led_out, frame_done); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME + 3; i++) begin
      tick(1'b0, 16'h0);
      n_cmp++; if (led_out !== exp_led()) begin n_bad++; $display("FAIL postrst_led e=%0d got %b want %b", e, led_out, exp_led()); end
      n_cmp++; if (digit_en !== exp_en()) begin n_bad++; $display("FAIL postrst_en e=%0d got %b want %b", e, digit_en, exp_en()); end
      n_cmp++; if (frame_done !== exp_fd()) begin n_bad++; $display("FAIL postrst_fd e=%0d got %b want %b", e, frame_done, exp_fd()); end
    end
    $display("test_invalid_bcd done: e=%0d", e);
  endtask

  task automatic test_leading_zero();
    logic [6:0] hi_want;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    hi_want = 7'b0000000;
`else
    hi_want = 7'b1111110;
`endif
    tick(1'b1, 16'h0050);
    while (e % FRAME != 0) tick(1'b0, 16'h0);
    while (e % FRAME != 20) begin
      tick(1'b0, 16'h0);
      n_cmp++; if (led_out !== exp_led()) begin n_bad++; $display("FAIL lz_led e=%0d got %b want %b", e, led_out, exp_led()); end
      if (e % FRAME == 2) begin
        n_cmp++; if (led_out !== 7'b1111110) begin n_bad++; $display("FAIL lz_d0 got %b want 1111110", led_out); end
      end
      if (e % FRAME == 8) begin
        n_cmp++; if (led_out !== 7'b1011011) begin n_bad++; $display("FAIL lz_d1 got %b want 1011011", led_out); end
      end
      if (e % FRAME == 14) begin
        n_cmp++; if (led_out !== hi_want || digit_en !== 4'b0100) begin n_bad++; $display("FAIL lz_d2 got %b/%b want 0100/%b", digit_en, led_out, hi_want); end
      end
    end
    n_cmp++; if (led_out !== hi_want || digit_en !== 4'b1000) begin n_bad++; $display("FAIL lz_d3 got %b/%b want 1000/%b", digit_en, led_out, hi_want); end
    $display("test_leading_zero done: e=%0d", e);
  endtask

  task automatic test_back_to_back();
    while (e % FRAME != 3) tick(1'b0, 16'h0);
    tick(1'b1, 16'h1111);
    tick(1'b1, 16'h2222);
    tick(1'b0, 16'h0);
    tick(1'b1, 16'h3333);
    while (e % FRAME != 2) tick(1'b0, 16'h0);
    n_cmp++; if (led_out !== 7'b1111001) begin n_bad++; $display("FAIL b2b_last_wins got %b want 1111001", led_out); end
    $display("test_back_to_back done: e=%0d led=%b", e, led_out);
  endtask

  task automatic test_random();
    logic        ld;
    logic [15:0] din;
    for (int i = 0; i < 400; i++) begin
      ld  = ($urandom_range(0, 7) == 0);
      din = 16'($urandom);
      tick(ld, din);
      n_cmp++; if (led_out !== exp_led()) begin n_bad++; $display("FAIL rnd_led e=%0d got %b want %b", e, led_out, exp_led()); end
      n_cmp++; if (digit_en !== exp_en()) begin n_bad++; $display("FAIL rnd_en e=%0d got %b want %b", e, digit_en, exp_en()); end
      n_cmp++; if (frame_done !== exp_fd()) begin n_bad++; $display("FAIL rnd_fd e=%0d got %b want %b", e, frame_done, exp_fd()); end
    end
    $display("test_random done: e=%0d", e);
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_double_buffer();
    test_wrap_load();
    test_invalid_bcd();
    test_leading_zero();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Multiplexed driver for a NUM_DIGITS-digit common-segment seven-segment display.
- Sits downstream of the BCD digit counters. It captures a packed BCD word and scans one digit at a time, with a blanking gap between digits to suppress ghosting.
- Display updates are double-buffered and only take effect at frame boundaries, so a frame never shows mixed digit values.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal range 2..8).
- REFRESH_COUNT, 4000, cycles each digit is lit per scan slot (>=1); 16 MHz / 4000 gives a 4 kHz slot rate.
- BLANK_CYCLES, 16, cycles all digits are off before each slot (>=1).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- digits_in  input  4*NUM_DIGITS  packed BCD; nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant.
- load  input  1  single-cycle strobe; captures digits_in into the shadow register.
- led_out  output  7  segments a..g, bit 6 = a ... bit 0 = g; active high; registered.
- digit_en  output  NUM_DIGITS  one-hot digit enable, active high; registered; all-zero while blanking.
- frame_done  output  1  one-cycle pulse on the cycle the FSM leaves SHOW of digit NUM_DIGITS-1.

Behaviour:
- Reset is asynchronous on reset_n low. Reset values:
  - state=BLANK, idx=0, slot counter=0.
  - shadow=0, active=0, pending=0.
  - led_out=0, digit_en=0, frame_done=0.
- FSM has two states, BLANK and SHOW.
  - BLANK: hold BLANK_CYCLES cycles with led_out=0 and digit_en=0, then go to SHOW.
  - SHOW: hold REFRESH_COUNT cycles with digit_en=(1<<idx) and led_out=seg(active nibble idx). Then go to BLANK and advance idx; idx wraps from NUM_DIGITS-1 to 0.
- Outputs are registered. They take the new state's values in the same clock edge that changes state, so there is no combinational path from inputs to outputs.
- Slot counter width is clog2(max(REFRESH_COUNT, BLANK_CYCLES)). It clears on every state change.
- Frame timing: period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_COUNT) cycles. frame_done pulses once per period.
- Load handling:
  - load=1 sets shadow<=digits_in and pending<=1.
  - At the frame wrap edge (SHOW idx=NUM_DIGITS-1 -> BLANK idx=0), if pending=1 then active<=shadow and pending<=0.
  - Simultaneous load and wrap edge: active<=digits_in directly, shadow<=digits_in, pending<=0.
  - Multiple loads within one frame: last one wins.
- Segment encoding, bits abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - 10..15 = 0000000 (blank).
- Reset mid-frame: outputs go to zero immediately (async). Scanning restarts at BLANK idx 0 on the first edge after release. Display shows all '0' digits until a load reaches a frame wrap.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: during SHOW of digit k (k>=1), led_out=0 when active nibbles NUM_DIGITS-1 down to k are all zero.
  - digit_en still asserts as normal, so timing is unchanged.
  - Digit 0 is never blanked by this rule.
- Undefined: zero digits display as '0'.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_COUNT=4, BLANK_CYCLES=2, so frame = 24 cycles.
- Reset: hold reset_n=0 -> led_out=0, digit_en=0, frame_done=0.
  - Release -> 2 cycles of zeros, then digit_en=0001 and led_out=1111110 for 4 cycles.
- Scan order: load digits_in=16'h4321 during frame 0, let it run into frame 1:
  - Frame 1 shows digit_en 0001/0010/0100/1000.
  - led_out in that order: 0110000, 1101101, 1111001, 0110011.
  - frame_done high exactly 1 cycle every 24 cycles.
- Double buffer: load 16'h9999 mid-frame (idx=2) -> remainder of frame unchanged. First slot after the wrap shows 1111011.
- Load on wrap edge: load=1 with 16'h0007 on the wrap cycle -> the frame starting at that edge shows 1110000 on digit 0. pending=0 afterwards.
- Invalid BCD and reset mid-SHOW:
  - digits_in=16'hFA00 -> digits 2,3 show 0000000 while digit_en still asserts.
  - Assert reset_n=0 mid-SHOW -> outputs 0 within the same cycle, no clock edge needed.
- SEG7_LEADING_ZERO_BLANK_EN defined, load 16'h0050:
  - Digits 3 and 2 show 0000000.
  - Digit 1 shows 1011011 and digit 0 shows 1111110.
  - Undefined: digits 3 and 2 show 1111110.
